// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin, packet-locking arbiter feeding one UART transmitter
// Each accepted byte is followed by a full frame of dead time before the next write.
module uart_tx_arbiter #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 115200,
  parameter int FRAME_BITS = 10,
  parameter int N_REQ      = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req_valid_i,
  input  logic [8*N_REQ-1:0]   req_data_i,
  input  logic [N_REQ-1:0]     req_last_i,
  output logic [N_REQ-1:0]     req_ready_o,
  output logic [N_REQ-1:0]     grant_o,
  output logic                 busy_o,
  output logic [7:0]           tx_data_o,
  output logic                 tx_wr_en_o
);

  localparam int FRAME_CYCLES = (CLK_FREQ / BAUD) * FRAME_BITS;
  localparam int CW = $clog2(FRAME_CYCLES);
  localparam int PW = $clog2(N_REQ);
  localparam logic [CW-1:0] CNT_LOAD = CW'(FRAME_CYCLES - 1);
  localparam logic [PW-1:0] LAST_IDX = PW'(N_REQ - 1);

  typedef enum logic [1:0] {IDLE, HOLD, WAIT} state_t;

  state_t            r_state;
  logic [PW-1:0]     r_ptr;
  logic [PW-1:0]     r_owner;
  logic              r_last;
  logic [CW-1:0]     r_cnt;

  logic [PW-1:0]     w_winner;
  logic              w_found;
  logic [PW-1:0]     w_sel;
  logic [N_REQ-1:0]  w_ready;
  logic              w_accept;
  logic [7:0]        w_data;

  // Scan from the highest offset down so the nearest valid index at or after r_ptr wins.
  always_comb begin
    logic [PW-1:0] v_idx;
    int            v_sum;
    w_winner = r_ptr;
    w_found  = 1'b0;
    v_idx    = '0;
    v_sum    = 0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      v_sum = int'(r_ptr) + k;
      if (v_sum >= N_REQ) v_sum = v_sum - N_REQ;
      v_idx = PW'(v_sum);
      if (req_valid_i[v_idx]) begin
        w_winner = v_idx;
        w_found  = 1'b1;
      end
    end
  end

  always_comb begin
    w_ready = '0;
    w_sel   = r_owner;
    if (rst) begin
      case (r_state)
        IDLE: begin
          w_sel = w_winner;
          if (w_found) w_ready[w_winner] = 1'b1;
        end
        HOLD:    w_ready[r_owner] = req_valid_i[r_owner];
        default: w_ready = '0;
      endcase
    end
  end

  assign w_accept    = |w_ready;
  assign w_data      = req_data_i[{w_sel, 3'b000} +: 8];
  assign req_ready_o = w_ready;
  assign busy_o      = (r_state != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_ptr      <= '0;
      r_owner    <= '0;
      r_last     <= 1'b0;
      r_cnt      <= '0;
      grant_o    <= '0;
      tx_data_o  <= 8'h00;
      tx_wr_en_o <= 1'b0;
    end else begin
      tx_wr_en_o <= 1'b0;
      if (w_accept) begin
        tx_data_o  <= w_data;
        tx_wr_en_o <= 1'b1;
        r_owner    <= w_sel;
        r_last     <= req_last_i[w_sel];
        grant_o    <= N_REQ'(1) << w_sel;
        r_cnt      <= CNT_LOAD;
        r_state    <= WAIT;
      end else if (r_state == WAIT) begin
        if (r_cnt == '0) begin
          if (r_last) begin
            r_state <= IDLE;
            grant_o <= '0;
            r_ptr   <= (r_owner == LAST_IDX) ? '0 : r_owner + 1'b1;
          end else begin
            r_state <= HOLD;
          end
        end else begin
          r_cnt <= r_cnt - 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - randomized self-checking bench for uart_tx_arbiter
// Expected byte order comes from a packet-level round-robin model over per-requester queues.
module tb_uart_tx_arbiter;
  localparam int CLK_FREQ   = 2_000_000;
  localparam int BAUD       = 115200;
  localparam int FRAME_BITS = 10;
  localparam int N          = 4;
  localparam int FC         = (CLK_FREQ / BAUD) * FRAME_BITS;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic [N-1:0]   req_valid_i = '0;
  logic [8*N-1:0] req_data_i = '0;
  logic [N-1:0]   req_last_i = '0;
  logic [N-1:0]   req_ready_o;
  logic [N-1:0]   grant_o;
  logic           busy_o;
  logic [7:0]     tx_data_o;
  logic           tx_wr_en_o;

  uart_tx_arbiter #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .FRAME_BITS(FRAME_BITS), .N_REQ(N)) dut (
    .clk(clk), .rst(rst), .req_valid_i(req_valid_i), .req_data_i(req_data_i),
    .req_last_i(req_last_i), .req_ready_o(req_ready_o), .grant_o(grant_o), .busy_o(busy_o),
    .tx_data_o(tx_data_o), .tx_wr_en_o(tx_wr_en_o)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_bad = 0;
  longint      cyc = 0;
  logic [8:0]  q [N][$];
  int          exp_own[$];
  logic [7:0]  exp_dat[$];
  int          got_own[$];
  logic [7:0]  got_dat[$];
  longint      got_cyc[$];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int oh2idx(input logic [N-1:0] v);
    if ($countones(v) != 1) return -1;
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic do_reset();
    req_valid_i = '0;
    req_last_i  = '0;
    req_data_i  = '0;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic gen_packet(input int r, input int len);
    logic [8:0] b;
    for (int j = 0; j < len; j++) begin
      b[7:0] = 8'($urandom_range(0, 255));
      b[8]   = (j == len - 1);
      q[r].push_back(b);
    end
  endtask

  task automatic model(input int p0);
    logic [8:0] mq [N][$];
    logic [8:0] b;
    int p, o;
    p = p0;
    exp_own.delete();
    exp_dat.delete();
    for (int i = 0; i < N; i++) mq[i] = q[i];
    forever begin
      o = -1;
      for (int k = 0; k < N; k++)
        if (o < 0 && mq[(p + k) % N].size() > 0) o = (p + k) % N;
      if (o < 0) break;
      do begin
        b = mq[o].pop_front();
        exp_own.push_back(o);
        exp_dat.push_back(b[7:0]);
      end while (!b[8] && mq[o].size() > 0);
      p = (o + 1) % N;
    end
  endtask

  task automatic drive_heads();
    for (int i = 0; i < N; i++) begin
      if (q[i].size() > 0) begin
        req_valid_i[i]        = 1'b1;
        req_data_i[8*i +: 8]  = q[i][0][7:0];
        req_last_i[i]         = q[i][0][8];
      end else begin
        req_valid_i[i] = 1'b0;
        req_last_i[i]  = 1'b0;
      end
    end
  endtask

  task automatic run_traffic(input string name, input int max_cycles);
    int  drain;
    bit  done;
    bit  empty;
    drain = 0;
    done  = 0;
    got_own.delete();
    got_dat.delete();
    got_cyc.delete();
    for (int c = 0; c < max_cycles && !done; c++) begin
      @(negedge clk);
      if (tx_wr_en_o) begin
        got_own.push_back(oh2idx(grant_o));
        got_dat.push_back(tx_data_o);
        got_cyc.push_back(cyc);
      end
      drive_heads();
      #1;
      n_cmp++;
      if ($countones(req_ready_o) > 1 || (req_ready_o & ~req_valid_i) != '0) begin
        n_bad++;
        $display("FAIL %s ready_onehot: got %b with valid %b", name, req_ready_o, req_valid_i);
      end
      for (int i = 0; i < N; i++) if (req_ready_o[i]) void'(q[i].pop_front());
      empty = 1;
      for (int i = 0; i < N; i++) if (q[i].size() > 0) empty = 0;
      if (empty) drain++;
      if (drain > 2 && !busy_o) done = 1;
    end
    req_valid_i = '0;
    n_cmp++;
    if (!done) begin
      n_bad++;
      $display("FAIL %s timeout: traffic not drained in %0d cycles, required drained", name, max_cycles);
    end
  endtask

  task automatic check_stream(input string name, input bit chk_spacing);
    n_cmp++;
    if (got_dat.size() !== exp_dat.size()) begin
      n_bad++;
      $display("FAIL %s count: got %0d bytes, expected %0d", name, got_dat.size(), exp_dat.size());
    end
    for (int k = 0; k < got_dat.size() && k < exp_dat.size(); k++) begin
      n_cmp++;
      if (got_own[k] !== exp_own[k] || got_dat[k] !== exp_dat[k]) begin
        n_bad++;
        $display("FAIL %s byte%0d: got req%0d 0x%02h, expected req%0d 0x%02h",
                 name, k, got_own[k], got_dat[k], exp_own[k], exp_dat[k]);
      end
    end
    if (chk_spacing) begin
      for (int k = 1; k < got_cyc.size(); k++) begin
        n_cmp++;
        if (got_cyc[k] - got_cyc[k-1] !== longint'(FC + 1)) begin
          n_bad++;
          $display("FAIL %s spacing%0d: got %0d cycles, expected %0d",
                   name, k, got_cyc[k] - got_cyc[k-1], FC + 1);
        end
      end
    end
  endtask

  task automatic test_reset();
    int bad;
    req_valid_i = '1;
    req_last_i  = '1;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    n_cmp++;
    if ({req_ready_o, grant_o, busy_o, tx_data_o, tx_wr_en_o} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: ready=%b grant=%b busy=%b data=%02h wr=%b, expected all 0",
               req_ready_o, grant_o, busy_o, tx_data_o, tx_wr_en_o);
    end
    req_valid_i = '0;
    req_last_i  = '0;
    @(negedge clk);
    rst = 1'b1;
    bad = 0;
    repeat (2000) begin
      @(negedge clk);
      if (tx_wr_en_o || busy_o || grant_o != '0 || tx_data_o != 8'h00) bad++;
    end
    n_cmp++;
    if (bad != 0) begin
      n_bad++;
      $display("FAIL idle_quiet: got %0d active cycles, expected 0", bad);
    end
  endtask

  task automatic test_single();
    int bc, extra;
    do_reset();
    @(negedge clk);
    req_valid_i = 4'b0100;
    req_last_i  = 4'b0100;
    req_data_i[23:16] = 8'h45;
    #1;
    n_cmp++;
    if (req_ready_o !== 4'b0100) begin
      n_bad++;
      $display("FAIL single_ready: got %b, expected 0100", req_ready_o);
    end
    @(negedge clk);
    req_valid_i = '0;
    n_cmp++;
    if (tx_wr_en_o !== 1'b1 || tx_data_o !== 8'h45 || grant_o !== 4'b0100 || busy_o !== 1'b1) begin
      n_bad++;
      $display("FAIL single_pulse: wr=%b data=%02h grant=%b busy=%b, expected 1 45 0100 1",
               tx_wr_en_o, tx_data_o, grant_o, busy_o);
    end
    bc = 1;
    extra = 0;
    for (int c = 0; c < FC + 10; c++) begin
      @(negedge clk);
      if (tx_wr_en_o) extra++;
      if (!busy_o) break;
      bc++;
    end
    n_cmp++;
    if (bc !== FC || extra !== 0 || grant_o !== '0) begin
      n_bad++;
      $display("FAIL single_busy: busy %0d cycles, %0d extra pulses, grant=%b, expected %0d 0 0000",
               bc, extra, grant_o, FC);
    end
    req_valid_i = 4'b1001;
    req_last_i  = 4'b1001;
    req_data_i[7:0]   = 8'h5A;
    req_data_i[31:24] = 8'hA5;
    #1;
    n_cmp++;
    if (req_ready_o !== 4'b1000) begin
      n_bad++;
      $display("FAIL ptr_after_single: got ready %b, expected 1000", req_ready_o);
    end
    @(negedge clk);
    req_valid_i = '0;
    n_cmp++;
    if (tx_data_o !== 8'hA5) begin
      n_bad++;
      $display("FAIL ptr_data: got %02h, expected a5", tx_data_o);
    end
    repeat (FC + 2) @(negedge clk);
  endtask

  task automatic test_packets();
    do_reset();
    for (int i = 0; i < N; i++) q[i].delete();
    gen_packet(0, 3);
    gen_packet(1, 3);
    model(0);
    run_traffic("packets", 8 * (FC + 1) + 50);
    check_stream("packets", 1'b1);
  endtask

  task automatic test_rotate();
    do_reset();
    for (int i = 0; i < N; i++) begin
      q[i].delete();
      gen_packet(i, 1);
      gen_packet(i, 1);
    end
    model(0);
    run_traffic("rotate", 10 * (FC + 1) + 50);
    check_stream("rotate", 1'b1);
  endtask

  task automatic test_random();
    int total;
    for (int it = 0; it < 2; it++) begin
      do_reset();
      total = 0;
      for (int i = 0; i < N; i++) begin
        q[i].delete();
        repeat ($urandom_range(0, 3)) begin
          int len;
          len = $urandom_range(1, 3);
          gen_packet(i, len);
          total += len;
        end
      end
      model(0);
      run_traffic("random", (total + 2) * (FC + 1) + 50);
      check_stream("random", 1'b1);
    end
  endtask

  task automatic test_stall();
    int bad;
    logic [7:0] b1, b2, b3;
    b1 = 8'($urandom_range(0, 255));
    b2 = 8'($urandom_range(0, 255));
    b3 = 8'($urandom_range(0, 255));
    do_reset();
    @(negedge clk);
    req_valid_i = 4'b1010;
    req_last_i  = 4'b1000;
    req_data_i[15:8]  = 8'h11;
    req_data_i[31:24] = b3;
    #1;
    n_cmp++;
    if (req_ready_o !== 4'b0010) begin
      n_bad++;
      $display("FAIL stall_first: got ready %b, expected 0010", req_ready_o);
    end
    @(negedge clk);
    req_valid_i = 4'b1000;
    bad = 0;
    repeat (2000) begin
      @(negedge clk);
      #1;
      if (tx_wr_en_o || grant_o !== 4'b0010 || req_ready_o !== '0) bad++;
    end
    n_cmp++;
    if (bad != 0) begin
      n_bad++;
      $display("FAIL stall_hold: got %0d violating cycles, expected 0", bad);
    end
    for (int i = 0; i < N; i++) q[i].delete();
    q[1].push_back({1'b0, b1});
    q[1].push_back({1'b1, b2});
    q[3].push_back({1'b1, b3});
    exp_own = '{1, 1, 3};
    exp_dat = '{b1, b2, b3};
    run_traffic("stall", 5 * (FC + 1) + 50);
    check_stream("stall", 1'b1);
  endtask

  task automatic test_reset_wait();
    do_reset();
    @(negedge clk);
    req_valid_i = 4'b0100;
    req_last_i  = 4'b0100;
    req_data_i[23:16] = 8'h11;
    @(negedge clk);
    req_valid_i = '0;
    repeat (FC + 2) @(negedge clk);
    req_valid_i = 4'b0010;
    req_last_i  = 4'b0000;
    req_data_i[15:8] = 8'h22;
    @(negedge clk);
    req_valid_i = '0;
    repeat (100) @(negedge clk);
    n_cmp++;
    if (busy_o !== 1'b1 || grant_o !== 4'b0010) begin
      n_bad++;
      $display("FAIL rstwait_pre: busy=%b grant=%b, expected 1 0010", busy_o, grant_o);
    end
    #2;
    rst = 1'b0;
    #1;
    n_cmp++;
    if ({req_ready_o, grant_o, busy_o, tx_data_o, tx_wr_en_o} !== '0) begin
      n_bad++;
      $display("FAIL rstwait_clear: ready=%b grant=%b busy=%b data=%02h wr=%b, expected all 0",
               req_ready_o, grant_o, busy_o, tx_data_o, tx_wr_en_o);
    end
    @(negedge clk);
    rst = 1'b1;
    req_valid_i = 4'b1001;
    req_last_i  = 4'b1001;
    req_data_i[7:0]   = 8'h33;
    req_data_i[31:24] = 8'h44;
    #1;
    n_cmp++;
    if (req_ready_o !== 4'b0001) begin
      n_bad++;
      $display("FAIL rstwait_ptr: got ready %b, expected 0001", req_ready_o);
    end
    @(negedge clk);
    req_valid_i = '0;
    n_cmp++;
    if (tx_wr_en_o !== 1'b1 || tx_data_o !== 8'h33) begin
      n_bad++;
      $display("FAIL rstwait_data: wr=%b data=%02h, expected 1 33", tx_wr_en_o, tx_data_o);
    end
    repeat (FC + 2) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single();
    test_packets();
    test_rotate();
    test_random();
    test_stall();
    test_reset_wait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
